ex_half_alu: RTL and testbench

EX_HALF_ALU -- requirements
Module: ex_half_alu

---
 rtl/rjsc5_pkg.sv | 38 +++
 rtl/half_addsub.sv | 20 ++
 rtl/ex_half_alu.sv | 162 ++++++++++++++++
 tb/tb_ex_half_alu.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rjsc5_pkg.sv
// Shared types and widths for the RJSC5 execute stage.
// RJSC5_EX_SLT_EN adds the SET state used by SLT/SLTU.
package rjsc5_pkg;

  localparam int unsigned HALF_W = 16;
  localparam int unsigned RD_W   = 5;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLT  = 3'd5,
    OP_SLTU = 3'd6,
    OP_RSVD = 3'd7
  } ex_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef RJSC5_EX_SLT_EN
    ST_SET  = 2'd2,
`endif
    ST_HI   = 2'd1
  } ex_state_t;

  // Ops whose adder input B is inverted with a +1 carry into the low half.
  function automatic logic op_is_sub(input ex_op_t op);
    return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
  endfunction

  // Ops that write both halves directly from the datapath.
  function automatic logic op_is_base(input ex_op_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/half_addsub.sv
// Combinational half-word add/subtract with carry-in and carry-out.
module half_addsub #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  input  logic         i_cin,
  output logic [W-1:0] o_sum_c,
  output logic         o_cout_c
);

  logic [W-1:0] w_b;
  logic [W:0]   w_full;

  assign w_b    = i_sub ? ~i_b : i_b;
  assign w_full = {1'b0, i_a} + {1'b0, w_b} + (W+1)'(i_cin);
  assign {o_cout_c, o_sum_c} = w_full;

endmodule

// File: rtl/ex_half_alu.sv
// Execute-stage ALU processing 32-bit operands as two 16-bit halves.
// Define RJSC5_EX_SLT_EN to enable SLT/SLTU (extra SET cycle).
module ex_half_alu #(
  parameter int unsigned HALF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_clken,
  input  logic              ex_valid,
  input  logic [2:0]        ex_op,
  input  logic [4:0]        ex_rd,
  input  logic [HALF_W+3:0] ex_src,
  input  logic [HALF_W-1:0] ex_src_b,
  output logic              ex_ready,
  output logic              rw_clken,
  output logic              rw_half,
  output logic [4:0]        rw_rd,
  output logic [HALF_W-1:0] rw_result
);
  import rjsc5_pkg::*;

  ex_state_t         r_state, w_state_nxt;
  ex_op_t            r_op, w_op_nxt, w_op;
  logic [RD_W-1:0]   r_rd, w_rd_nxt;
  logic              r_carry, w_carry_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_rw_clken, w_rw_clken_nxt;
  logic              r_rw_half, w_rw_half_nxt;
  logic [RD_W-1:0]   r_rw_rd, w_rw_rd_nxt;
  logic [HALF_W-1:0] r_rw_result, w_rw_result_nxt;
  logic [HALF_W-1:0] w_a, w_sum, w_alu;
  logic              w_sub, w_cin, w_cout;
  logic              w_unused_src;

  assign w_a          = ex_src[HALF_W-1:0];
  assign w_unused_src = ^ex_src[HALF_W+3:HALF_W];

  // The op comes from the port while accepting, from the latch in later steps.
  assign w_op  = (r_state == ST_IDLE) ? ex_op_t'(ex_op) : r_op;
  assign w_sub = op_is_sub(w_op);
  assign w_cin = (r_state == ST_IDLE) ? w_sub : r_carry;

  half_addsub #(.W(HALF_W)) u_addsub (
    .i_a      (w_a),
    .i_b      (ex_src_b),
    .i_sub    (w_sub),
    .i_cin    (w_cin),
    .o_sum_c  (w_sum),
    .o_cout_c (w_cout)
  );

  always_comb begin
    case (w_op)
      OP_AND:  w_alu = w_a & ex_src_b;
      OP_OR:   w_alu = w_a | ex_src_b;
      OP_XOR:  w_alu = w_a ^ ex_src_b;
      default: w_alu = w_sum;
    endcase
  end

`ifdef RJSC5_EX_SLT_EN
  logic r_lt, w_lt_nxt, w_lt_c;

  // Signed compare: differing signs decide directly, else the difference sign.
  assign w_lt_c = (w_op == OP_SLTU) ? ~w_cout :
                  (w_a[HALF_W-1] != ex_src_b[HALF_W-1]) ? w_a[HALF_W-1] : w_sum[HALF_W-1];
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_rd_nxt        = r_rd;
    w_carry_nxt     = r_carry;
    w_rw_clken_nxt  = 1'b0;
    w_rw_half_nxt   = r_rw_half;
    w_rw_rd_nxt     = r_rw_rd;
    w_rw_result_nxt = r_rw_result;
`ifdef RJSC5_EX_SLT_EN
    w_lt_nxt        = r_lt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (ex_valid) begin
          w_op_nxt        = w_op;
          w_rd_nxt        = ex_rd;
          w_carry_nxt     = w_cout;
          w_rw_clken_nxt  = op_is_base(w_op);
          w_rw_half_nxt   = 1'b0;
          w_rw_rd_nxt     = ex_rd;
          w_rw_result_nxt = w_alu;
          w_state_nxt     = ST_HI;
        end
      end
      ST_HI: begin
        w_rw_clken_nxt  = op_is_base(r_op);
        w_rw_half_nxt   = 1'b1;
        w_rw_rd_nxt     = r_rd;
        w_rw_result_nxt = w_alu;
        w_state_nxt     = ST_IDLE;
`ifdef RJSC5_EX_SLT_EN
        if ((r_op == OP_SLT) || (r_op == OP_SLTU)) begin
          w_rw_clken_nxt  = 1'b1;
          w_rw_result_nxt = '0;
          w_lt_nxt        = w_lt_c;
          w_state_nxt     = ST_SET;
        end
`endif
      end
`ifdef RJSC5_EX_SLT_EN
      ST_SET: begin
        w_rw_clken_nxt  = 1'b1;
        w_rw_half_nxt   = 1'b0;
        w_rw_rd_nxt     = r_rd;
        w_rw_result_nxt = {(HALF_W-1)'(0), r_lt};
        w_state_nxt     = ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  // Everything holds while the stage is stalled; only the write strobe drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_ADD;
      r_rd        <= '0;
      r_carry     <= 1'b0;
      r_ready     <= 1'b1;
      r_rw_clken  <= 1'b0;
      r_rw_half   <= 1'b0;
      r_rw_rd     <= '0;
      r_rw_result <= '0;
`ifdef RJSC5_EX_SLT_EN
      r_lt        <= 1'b0;
`endif
    end else if (ex_clken) begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_rd        <= w_rd_nxt;
      r_carry     <= w_carry_nxt;
      r_ready     <= w_ready_nxt;
      r_rw_clken  <= w_rw_clken_nxt;
      r_rw_half   <= w_rw_half_nxt;
      r_rw_rd     <= w_rw_rd_nxt;
      r_rw_result <= w_rw_result_nxt;
`ifdef RJSC5_EX_SLT_EN
      r_lt        <= w_lt_nxt;
`endif
    end else begin
      r_rw_clken  <= 1'b0;
    end
  end

  assign ex_ready  = r_ready;
  assign rw_clken  = r_rw_clken;
  assign rw_half   = r_rw_half;
  assign rw_rd     = r_rw_rd;
  assign rw_result = r_rw_result;

endmodule

// File: tb/tb_ex_half_alu.sv
// Directed self-checking bench for ex_half_alu (both RJSC5_EX_SLT_EN builds).
module tb_ex_half_alu;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        ex_clken = 1'b0;
  logic        ex_valid = 1'b0;
  logic [2:0]  ex_op    = 3'd0;
  logic [4:0]  ex_rd    = 5'd0;
  logic [19:0] ex_src   = 20'd0;
  logic [15:0] ex_src_b = 16'd0;
  logic        ex_ready;
  logic        rw_clken;
  logic        rw_half;
  logic [4:0]  rw_rd;
  logic [15:0] rw_result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_half_alu #(.HALF_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .ex_clken  (ex_clken),
    .ex_valid  (ex_valid),
    .ex_op     (ex_op),
    .ex_rd     (ex_rd),
    .ex_src    (ex_src),
    .ex_src_b  (ex_src_b),
    .ex_ready  (ex_ready),
    .rw_clken  (rw_clken),
    .rw_half   (rw_half),
    .rw_rd     (rw_rd),
    .rw_result (rw_result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lo(input logic [2:0] op, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b);
    ex_clken = 1'b1;
    ex_valid = 1'b1;
    ex_op    = op;
    ex_rd    = rd;
    ex_src   = {4'hA, a[15:0]};
    ex_src_b = b[15:0];
    step();
  endtask

  // ex_valid stays high across the high-half edge; it must be ignored there.
  task automatic drive_hi(input logic [31:0] a, input logic [31:0] b);
    ex_clken = 1'b1;
    ex_valid = 1'b1;
    ex_src   = {4'h5, a[31:16]};
    ex_src_b = b[31:16];
    step();
    ex_valid = 1'b0;
  endtask

  task automatic run_two(input string tag, input logic [2:0] op, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] exp_lo, input logic [15:0] exp_hi);
    drive_lo(op, rd, a, b);
    check({tag, ".lo.clken"}, 32'(rw_clken), 32'd1);
    check({tag, ".lo.half"}, 32'(rw_half), 32'd0);
    check({tag, ".lo.rd"}, 32'(rw_rd), 32'(rd));
    check({tag, ".lo.result"}, 32'(rw_result), 32'(exp_lo));
    check({tag, ".lo.ready"}, 32'(ex_ready), 32'd0);
    drive_hi(a, b);
    check({tag, ".hi.clken"}, 32'(rw_clken), 32'd1);
    check({tag, ".hi.half"}, 32'(rw_half), 32'd1);
    check({tag, ".hi.rd"}, 32'(rw_rd), 32'(rd));
    check({tag, ".hi.result"}, 32'(rw_result), 32'(exp_hi));
    check({tag, ".hi.ready"}, 32'(ex_ready), 32'd1);
    step();
    check({tag, ".idle.clken"}, 32'(rw_clken), 32'd0);
  endtask

  task automatic run_rsvd(input string tag, input logic [2:0] op);
    drive_lo(op, 5'd17, 32'hFFFFFFFF, 32'h00000001);
    check({tag, ".c1.clken"}, 32'(rw_clken), 32'd0);
    check({tag, ".c1.ready"}, 32'(ex_ready), 32'd0);
    drive_hi(32'hFFFFFFFF, 32'h00000001);
    check({tag, ".c2.clken"}, 32'(rw_clken), 32'd0);
    check({tag, ".c2.ready"}, 32'(ex_ready), 32'd1);
    step();
    check({tag, ".c3.clken"}, 32'(rw_clken), 32'd0);
  endtask

`ifdef RJSC5_EX_SLT_EN
  task automatic run_slt(input string tag, input logic [2:0] op, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input logic exp_lt);
    drive_lo(op, rd, a, b);
    check({tag, ".c1.clken"}, 32'(rw_clken), 32'd0);
    check({tag, ".c1.ready"}, 32'(ex_ready), 32'd0);
    drive_hi(a, b);
    check({tag, ".hi.clken"}, 32'(rw_clken), 32'd1);
    check({tag, ".hi.half"}, 32'(rw_half), 32'd1);
    check({tag, ".hi.result"}, 32'(rw_result), 32'd0);
    check({tag, ".hi.ready"}, 32'(ex_ready), 32'd0);
    step();
    check({tag, ".set.clken"}, 32'(rw_clken), 32'd1);
    check({tag, ".set.half"}, 32'(rw_half), 32'd0);
    check({tag, ".set.rd"}, 32'(rw_rd), 32'(rd));
    check({tag, ".set.result"}, 32'(rw_result), 32'(exp_lt));
    check({tag, ".set.ready"}, 32'(ex_ready), 32'd1);
    step();
    check({tag, ".idle.clken"}, 32'(rw_clken), 32'd0);
  endtask
`endif

  initial begin
    reset    = 1'b0;
    ex_clken = 1'b1;
    repeat (3) step();
    check("rst.ready", 32'(ex_ready), 32'd1);
    check("rst.clken", 32'(rw_clken), 32'd0);
    check("rst.half", 32'(rw_half), 32'd0);
    check("rst.rd", 32'(rw_rd), 32'd0);
    check("rst.result", 32'(rw_result), 32'd0);
    reset = 1'b1;
    step();
    check("idle.clken", 32'(rw_clken), 32'd0);

    run_two("add",      3'd0, 5'd5,  32'h0001FFFF, 32'h00000001, 16'h0000, 16'h0002);
    run_two("sub",      3'd1, 5'd6,  32'h00010000, 32'h00000001, 16'hFFFF, 16'h0000);
    run_two("and",      3'd2, 5'd7,  32'h12345678, 32'h0F0FF0F0, 16'h5070, 16'h0204);
    run_two("or",       3'd3, 5'd8,  32'h12345678, 32'h0F0FF0F0, 16'hF6F8, 16'h1F3F);
    run_two("xor",      3'd4, 5'd9,  32'h12345678, 32'h0F0FF0F0, 16'hA688, 16'h1D3B);
    run_two("sub_wrap", 3'd1, 5'd10, 32'h00000000, 32'h00000001, 16'hFFFF, 16'hFFFF);
    run_two("add_wrap", 3'd0, 5'd11, 32'hFFFFFFFF, 32'h00000001, 16'h0000, 16'h0000);

`ifdef RJSC5_EX_SLT_EN
    run_slt("slt_neg",  3'd5, 5'd12, 32'hFFFFFFFF, 32'h00000001, 1'b1);
    run_slt("sltu_neg", 3'd6, 5'd13, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    run_slt("slt_pos",  3'd5, 5'd14, 32'h00000001, 32'hFFFFFFFF, 1'b0);
    run_slt("sltu_pos", 3'd6, 5'd15, 32'h00000001, 32'hFFFFFFFF, 1'b1);
`else
    run_rsvd("slt_off", 3'd5);
    run_rsvd("sltu_off", 3'd6);
`endif
    run_rsvd("op7", 3'd7);

    // Stall between halves: strobe drops, carry survives.
    drive_lo(3'd0, 5'd3, 32'h0001FFFF, 32'h00000001);
    check("stall.lo.clken", 32'(rw_clken), 32'd1);
    check("stall.lo.result", 32'(rw_result), 32'h0000);
    ex_clken = 1'b0;
    ex_valid = 1'b0;
    ex_src   = 20'h7BEEF;
    ex_src_b = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall.c%0d.clken", i), 32'(rw_clken), 32'd0);
    end
    check("stall.hold.result", 32'(rw_result), 32'h0000);
    check("stall.hold.half", 32'(rw_half), 32'd0);
    check("stall.hold.ready", 32'(ex_ready), 32'd0);
    drive_hi(32'h0001FFFF, 32'h00000001);
    check("stall.hi.clken", 32'(rw_clken), 32'd1);
    check("stall.hi.half", 32'(rw_half), 32'd1);
    check("stall.hi.result", 32'(rw_result), 32'h0002);
    step();

    // Reset while in HI abandons the operation.
    drive_lo(3'd0, 5'd12, 32'h0001FFFF, 32'h00000001);
    check("rstmid.lo.clken", 32'(rw_clken), 32'd1);
    reset = 1'b0;
    #1;
    check("rstmid.clken", 32'(rw_clken), 32'd0);
    check("rstmid.result", 32'(rw_result), 32'd0);
    check("rstmid.rd", 32'(rw_rd), 32'd0);
    check("rstmid.ready", 32'(ex_ready), 32'd1);
    ex_valid = 1'b0;
    ex_src   = 20'h00001;
    ex_src_b = 16'h0000;
    step();
    reset = 1'b1;
    step();
    check("rstmid.after1.clken", 32'(rw_clken), 32'd0);
    step();
    check("rstmid.after2.clken", 32'(rw_clken), 32'd0);
    check("rstmid.after2.ready", 32'(ex_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
